// File: rtl/mrcs_tt2_pkg.sv
// Shared constants, FSM states and LFSR helper for the MRCS TT2 cell checker.
package mrcs_tt2_pkg;

  // Bit positions of the tile outputs
  localparam int unsigned O_ZOOK    = 0;
  localparam int unsigned O_DFF_Q   = 1;
  localparam int unsigned O_DFF_M   = 2;
  localparam int unsigned O_NAND_Q  = 3;
  localparam int unsigned O_NAND_QN = 4;
  localparam int unsigned O_SR_Q    = 5;
  localparam int unsigned O_SR_QN   = 6;
  localparam int unsigned O_EDGE    = 7;

  localparam int unsigned OUT_W  = 8;
  localparam int unsigned LFSR_W = 8;

  // Galois taps for x^8+x^6+x^5+x^4+1, right-shifting form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    CHECK,
    DONE
  } state_e;

  // One Galois LFSR shift
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : LFSR_W'(0));
  endfunction

endpackage

// File: rtl/mrcs_golden_model.sv
// Cycle-level reference of the storage-cell tile with per-bit validity tracking.
// expected/valid show the tile state after applying the current (a,b) step to the
// committed state; commit makes that step's state permanent.
module mrcs_golden_model
  import mrcs_tt2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             commit,
  input  logic             a,
  input  logic             b,
  output logic [OUT_W-1:0] expected,
  output logic [OUT_W-1:0] valid
);

  logic q0_q, m_q, q1_q, q3_q, sr_q_q, sr_qn_q;
  logic v0_q, vm_q, v1_q, v3_q, vsr_q;
  logic prev_a_q, prev_vld_q, prev_00_q;

  logic q0_n, m_n, q1_n, q3_n, sr_q_n, sr_qn_n;
  logic v0_n, vm_n, v1_n, v3_n, vsr_n;
  logic rise;

  // Post-step state of every modelled cell
  always_comb begin
    q0_n    = q0_q;
    m_n     = m_q;
    q1_n    = q1_q;
    q3_n    = q3_q;
    sr_q_n  = sr_q_q;
    sr_qn_n = sr_qn_q;
    v0_n    = v0_q;
    vm_n    = vm_q;
    v1_n    = v1_q;
    v3_n    = v3_q;
    vsr_n   = vsr_q;
    rise    = prev_vld_q & ~prev_a_q & a;
    if (!a) begin
      q0_n = b;
      v0_n = 1'b1;
      m_n  = b;
      vm_n = 1'b1;
    end
    if (rise) begin
      q1_n = m_q;
      v1_n = vm_q;
    end
    if (a) begin
      q3_n = b;
      v3_n = 1'b1;
    end
    case ({a, b})
      2'b01: begin sr_q_n = 1'b1; sr_qn_n = 1'b0; vsr_n = 1'b1; end
      2'b10: begin sr_q_n = 1'b0; sr_qn_n = 1'b1; vsr_n = 1'b1; end
      2'b00: begin sr_q_n = 1'b1; sr_qn_n = 1'b1; vsr_n = 1'b1; end
      default: begin
        // Releasing both inputs together races the latch: outcome unknown
        if (prev_00_q) vsr_n = 1'b0;
      end
    endcase
  end

  // Pack expected values and valid flags by output position
  always_comb begin
    expected            = '0;
    valid               = '0;
    expected[O_ZOOK]    = q0_n;
    expected[O_DFF_Q]   = q1_n;
    expected[O_DFF_M]   = m_n;
    expected[O_NAND_Q]  = q3_n;
    expected[O_NAND_QN] = ~q3_n;
    expected[O_SR_Q]    = sr_q_n;
    expected[O_SR_QN]   = sr_qn_n;
    expected[O_EDGE]    = 1'b0;
    valid[O_ZOOK]       = v0_n;
    valid[O_DFF_Q]      = v1_n;
    valid[O_DFF_M]      = vm_n;
    valid[O_NAND_Q]     = v3_n;
    valid[O_NAND_QN]    = v3_n;
    valid[O_SR_Q]       = vsr_n;
    valid[O_SR_QN]      = vsr_n;
    valid[O_EDGE]       = 1'b1;
  end

  // Model state, cleared at reset or run start, advanced once per checked step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {q0_q, m_q, q1_q, q3_q, sr_q_q, sr_qn_q} <= '0;
      {v0_q, vm_q, v1_q, v3_q, vsr_q}          <= '0;
      {prev_a_q, prev_vld_q, prev_00_q}        <= '0;
    end else if (clear) begin
      {q0_q, m_q, q1_q, q3_q, sr_q_q, sr_qn_q} <= '0;
      {v0_q, vm_q, v1_q, v3_q, vsr_q}          <= '0;
      {prev_a_q, prev_vld_q, prev_00_q}        <= '0;
    end else if (commit) begin
      q0_q       <= q0_n;
      m_q        <= m_n;
      q1_q       <= q1_n;
      q3_q       <= q3_n;
      sr_q_q     <= sr_q_n;
      sr_qn_q    <= sr_qn_n;
      v0_q       <= v0_n;
      vm_q       <= vm_n;
      v1_q       <= v1_n;
      v3_q       <= v3_n;
      vsr_q      <= vsr_n;
      prev_a_q   <= a;
      prev_vld_q <= 1'b1;
      prev_00_q  <= ~a & ~b;
    end
  end

endmodule

// File: rtl/c_tt2_mrcs_cell_checker.sv
// Self-test sequencer for the MRCS storage-cell tile: drives LFSR (A,B) steps,
// samples the synchronized tile outputs and scores them against the golden model.
module c_tt2_mrcs_cell_checker
  import mrcs_tt2_pkg::*;
#(
  parameter int unsigned       NUM_STEPS = 64,
  parameter int unsigned       SETTLE    = 4,
  parameter logic [LFSR_W-1:0] SEED      = 8'hA5,
  parameter int unsigned       ERR_W     = 8,
  parameter int unsigned       STEP_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              stim_a,
  output logic              stim_b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [OUT_W-1:0]  fail_mask,
  output logic [STEP_W-1:0] step_idx
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e              state_q, state_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [OUT_W-1:0]    sync1_q, sync2_q, samp_q, samp_d;
  logic                stim_a_d, stim_b_d, busy_d, done_d, pass_d;
  logic [ERR_W-1:0]    err_cnt_d;
  logic [OUT_W-1:0]    fail_mask_d;
  logic [STEP_W-1:0]   step_idx_d;
  logic                model_clear_c, model_commit_c;
  logic [OUT_W-1:0]    exp_c, vld_c, diff_c;
  logic [LFSR_W-1:0]   lfsr_adv_c;
  logic                last_step_c;

  assign diff_c      = (samp_q ^ exp_c) & vld_c;
  assign lfsr_adv_c  = lfsr_next(lfsr_q);
  assign last_step_c = (step_idx == STEP_W'(NUM_STEPS - 1));

  mrcs_golden_model u_model (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (model_clear_c),
    .commit   (model_commit_c),
    .a        (stim_a),
    .b        (stim_b),
    .expected (exp_c),
    .valid    (vld_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = DRIVE;
      DRIVE:      if (set_cnt_q == SET_W'(SETTLE - 1)) state_d = SAMPLE;
      SAMPLE:     state_d = CHECK;
      CHECK:      state_d = last_step_c ? DONE : DRIVE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    set_cnt_d      = set_cnt_q;
    lfsr_d         = lfsr_q;
    samp_d         = samp_q;
    stim_a_d       = stim_a;
    stim_b_d       = stim_b;
    busy_d         = busy;
    done_d         = done;
    pass_d         = pass;
    err_cnt_d      = err_cnt;
    fail_mask_d    = fail_mask;
    step_idx_d     = step_idx;
    model_clear_c  = 1'b0;
    model_commit_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          set_cnt_d     = '0;
          lfsr_d        = SEED;
          stim_a_d      = SEED[1];
          stim_b_d      = SEED[0];
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          err_cnt_d     = '0;
          fail_mask_d   = '0;
          step_idx_d    = '0;
          model_clear_c = 1'b1;
        end
      end
      DRIVE:  set_cnt_d = set_cnt_q + SET_W'(1);
      SAMPLE: samp_d = sync2_q;
      CHECK: begin
        model_commit_c = 1'b1;
        set_cnt_d      = '0;
        if (|diff_c) begin
          fail_mask_d = fail_mask | diff_c;
          if (err_cnt != {ERR_W{1'b1}}) err_cnt_d = err_cnt + ERR_W'(1);
        end
        lfsr_d     = lfsr_adv_c;
        step_idx_d = step_idx + STEP_W'(1);
        if (last_step_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_cnt_d == '0);
        end else begin
          stim_a_d = lfsr_adv_c[1];
          stim_b_d = lfsr_adv_c[0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt_q <= '0;
      lfsr_q    <= SEED;
      samp_q    <= '0;
      stim_a    <= 1'b1;
      stim_b    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_mask <= '0;
      step_idx  <= '0;
    end else begin
      set_cnt_q <= set_cnt_d;
      lfsr_q    <= lfsr_d;
      samp_q    <= samp_d;
      stim_a    <= stim_a_d;
      stim_b    <= stim_b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err_cnt   <= err_cnt_d;
      fail_mask <= fail_mask_d;
      step_idx  <= step_idx_d;
    end
  end

  // Two-flop synchronizer for the asynchronous tile outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dut_out;
      sync2_q <= sync1_q;
    end
  end

endmodule

// File: tb/tb_c_tt2_mrcs_cell_checker.sv
// Directed bench: behavioural tile model driving two checker instances
// (default widths, and ERR_W=2 fed an inverted tile).
module tb_c_tt2_mrcs_cell_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stuck3 = 1'b0;
  logic [7:0] tile_out, dut_out1, dut_out2;

  logic       stim_a, stim_b, busy, done, pass;
  logic [7:0] err_cnt, fail_mask;
  logic [6:0] step_idx;

  logic       stim_a2, stim_b2, busy2, done2, pass2;
  logic [1:0] err_cnt2;
  logic [7:0] fail_mask2;
  logic [6:0] step_idx2;

  int n_checks = 0;
  int n_errors = 0;
  int races = 0;

  always #5 clk = ~clk;

  c_tt2_mrcs_cell_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out1),
    .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_mask(fail_mask), .step_idx(step_idx)
  );

  c_tt2_mrcs_cell_checker #(.ERR_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out2),
    .stim_a(stim_a2), .stim_b(stim_b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .fail_mask(fail_mask2), .step_idx(step_idx2)
  );

  // Behavioural tile, settled each negedge from the checker's drive lines.
  // A 00->11 release resolves the SR latch to an implausible 0/0.
  logic t_q0 = 0, t_m = 0, t_q1 = 0, t_q3 = 0, t_sq = 0, t_sqn = 0, t_last_a = 1;
  logic [1:0] t_last_ab = 2'b11;
  always @(negedge clk) begin
    if (!stim_a) begin t_q0 = stim_b; t_m = stim_b; end
    if (!t_last_a && stim_a) t_q1 = t_m;
    if (stim_a) t_q3 = stim_b;
    case ({stim_a, stim_b})
      2'b01: begin t_sq = 1'b1; t_sqn = 1'b0; end
      2'b10: begin t_sq = 1'b0; t_sqn = 1'b1; end
      2'b00: begin t_sq = 1'b1; t_sqn = 1'b1; end
      default: if (t_last_ab == 2'b00) begin t_sq = 1'b0; t_sqn = 1'b0; races++; end
    endcase
    t_last_a  = stim_a;
    t_last_ab = {stim_a, stim_b};
  end

  assign tile_out = {1'b0, t_sqn, t_sq, ~t_q3, t_q3, t_m, t_q1, t_q0};
  assign dut_out1 = stuck3 ? (tile_out & 8'hF7) : tile_out;
  assign dut_out2 = {1'b0, ~tile_out[6:0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference count of steps where q3 is defined and 1 (seed A5, 64 steps)
  function automatic int q3_one_steps();
    logic [7:0] l = 8'hA5;
    logic q3 = 1'b0, v3 = 1'b0;
    int c = 0;
    for (int k = 0; k < 64; k++) begin
      if (l[1]) begin q3 = l[0]; v3 = 1'b1; end
      if (v3 && q3) c++;
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    end
    return c;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_stim_a"},   32'(stim_a),    32'd1);
    check_eq({tag, "_stim_b"},   32'(stim_b),    32'd1);
    check_eq({tag, "_busy"},     32'(busy),      32'd0);
    check_eq({tag, "_done"},     32'(done),      32'd0);
    check_eq({tag, "_pass"},     32'(pass),      32'd0);
    check_eq({tag, "_err_cnt"},  32'(err_cnt),   32'd0);
    check_eq({tag, "_fail_mask"},32'(fail_mask), 32'd0);
    check_eq({tag, "_step_idx"}, 32'(step_idx),  32'd0);
  endtask

  // Start a run; optionally check early stimulus and poke start mid-run.
  task automatic run(input bit check_stim, input bit poke_busy, output int cycles);
    logic [1:0] ab_tbl [0:8];
    ab_tbl = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(posedge clk);
      #1 cycles++;
      if (check_stim && cycles % 6 == 2 && cycles / 6 < 9) begin
        check_eq($sformatf("stim_step%0d", cycles / 6),
                 32'({stim_a, stim_b}), 32'(ab_tbl[cycles / 6]));
        check_eq($sformatf("step_idx%0d", cycles / 6), 32'(step_idx), 32'(cycles / 6));
      end
      if (check_stim && cycles == 3) check_eq("busy_mid", 32'(busy), 32'd1);
      if (poke_busy) start = (cycles == 120);
    end
    start = 1'b0;
    if (!done) check_eq("run_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Ideal tile, start poked mid-run, race case resolves oddly but is masked
    run(1'b1, 1'b1, cyc);
    check_eq("run_len",     32'(cyc),       32'd384);
    check_eq("ideal_done",  32'(done),      32'd1);
    check_eq("ideal_busy",  32'(busy),      32'd0);
    check_eq("ideal_pass",  32'(pass),      32'd1);
    check_eq("ideal_err",   32'(err_cnt),   32'd0);
    check_eq("ideal_mask",  32'(fail_mask), 32'd0);
    $display("info: 00->11 release steps seen: %0d", races);
    // Inverted tile on the narrow-counter instance
    check_eq("inv_done",    32'(done2),      32'd1);
    check_eq("inv_pass",    32'(pass2),      32'd0);
    check_eq("inv_err_sat", 32'(err_cnt2),   32'd3);
    check_eq("inv_mask",    32'(fail_mask2), 32'h7F);

    // Done holds until the next start
    repeat (5) @(posedge clk);
    #1 check_eq("done_hold", 32'(done), 32'd1);

    // NAND latch Q stuck at 0
    stuck3 = 1'b1;
    run(1'b0, 1'b0, cyc);
    check_eq("stuck_pass", 32'(pass),      32'd0);
    check_eq("stuck_mask", 32'(fail_mask), 32'h08);
    check_eq("stuck_err",  32'(err_cnt),   32'(q3_one_steps()));
    stuck3 = 1'b0;

    // Abort with reset at step 10
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (step_idx != 7'd10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("reach_step10", 32'(step_idx), 32'd10);
    rst_n = 1'b0;
    @(posedge clk);
    #1 check_reset_vals("abort");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run(1'b0, 1'b0, cyc);
    check_eq("rerun_len",  32'(cyc),       32'd384);
    check_eq("rerun_pass", 32'(pass),      32'd1);
    check_eq("rerun_err",  32'(err_cnt),   32'd0);
    check_eq("rerun_mask", 32'(fail_mask), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
